// File: rtl/dmem_access.sv
// dmem_access
//
// Data-memory access stage sitting in front of the load-data extractor.
// Accepts load/store requests from execute, builds byte enables, replicates
// store data across the byte lanes, checks alignment and drives a
// ready/valid request onto the data bus. The completed access returns the
// raw read word together with its byte enable and funct3 op; lane select and
// sign/zero extension happen in the next stage.
//
// Parameters
//   TIMEOUT            bus-wait cycles before abort with resp_err_o (0 = never)
//
// Build option
//   MISALIGN_TRAP_EN   when defined, misaligned requests are trapped and
//                      reported through resp_misalign_o without a bus access;
//                      when undefined, the offending low address bits are
//                      dropped and the access proceeds normally.
//
// Ports
//   clk_i              clock
//   rst_ni             asynchronous active-low reset
//   req_valid_i/ready_o request handshake from execute (ready only in IDLE)
//   req_wr_i           1 = store, 0 = load
//   req_op_i           funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu
//   req_addr_i         byte address
//   req_sdata_i        right-aligned store data
//   mem_valid_o/ready_i bus handshake
//   mem_addr_o         word-aligned bus address
//   mem_wdata_o        lane-replicated store data
//   mem_wstrb_o        byte strobes (0 for loads)
//   mem_rdata_i        read word, valid with mem_ready_i
//   resp_valid_o       one-cycle completion pulse
//   resp_ldata_o       raw captured read word (0 for stores)
//   resp_byteenable_o  byte enable of the completed access
//   resp_op_o          funct3 of the completed access
//   resp_err_o         bus timeout, qualified by resp_valid_o
//   resp_misalign_o    misaligned access trapped, qualified by resp_valid_o

module dmem_access #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_wr_i,
    input  logic [2:0]  req_op_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_sdata_i,
    output logic        mem_valid_o,
    input  logic        mem_ready_i,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_wstrb_o,
    input  logic [31:0] mem_rdata_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_ldata_o,
    output logic [3:0]  resp_byteenable_o,
    output logic [2:0]  resp_op_o,
    output logic        resp_err_o,
    output logic        resp_misalign_o
);

    localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e        state_q;
    logic [CW-1:0] waitCnt_q;
    logic          wr_q;
    logic [3:0]    byteEn_q;
    logic [2:0]    op_q;

    logic          memValid_q;
    logic [31:0]   memAddr_q;
    logic [31:0]   memWdata_q;
    logic [3:0]    memWstrb_q;
    logic          respValid_q;
    logic [31:0]   respLdata_q;
    logic [3:0]    respByteEn_q;
    logic [2:0]    respOp_q;
    logic          respErr_q;
    logic          respMisalign_q;

    logic          isByte;
    logic          isHalf;
    logic [3:0]    byteEn_d;
    logic [31:0]   wdata_d;
    logic          trapReq;
    logic          timeoutHit;

    // Only 00 (b/bu) and 01 (h/hu) in the low op bits select narrow accesses;
    // every other encoding, including the reserved ones, behaves as a word.
    assign isByte = (req_op_i[1:0] == 2'b00);
    assign isHalf = (req_op_i[1:0] == 2'b01);

    // Byte enable and store-data replication for the incoming request. The
    // bus address is always word aligned, so dropping misaligned low bits in
    // the non-trapping build only shows up here: a halfword keeps addr[1]
    // and a word always enables all four lanes.
    always_comb begin
        byteEn_d = 4'hF;
        wdata_d  = req_sdata_i;
        trapReq  = 1'b0;
        if (isByte) begin
            byteEn_d = 4'b0001 << req_addr_i[1:0];
            wdata_d  = {4{req_sdata_i[7:0]}};
        end else if (isHalf) begin
            byteEn_d = req_addr_i[1] ? 4'hC : 4'h3;
            wdata_d  = {2{req_sdata_i[15:0]}};
        end
`ifdef MISALIGN_TRAP_EN
        trapReq = isHalf ? req_addr_i[0] : (!isByte && (req_addr_i[1:0] != 2'b00));
`endif
    end

    assign timeoutHit = (TIMEOUT != 0) && (waitCnt_q == CNT_LAST);

    // Control FSM with all bus and response outputs registered. A bus
    // completion in the same cycle as timeout expiry takes priority.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= IDLE;
            waitCnt_q      <= '0;
            wr_q           <= 1'b0;
            byteEn_q       <= 4'h0;
            op_q           <= 3'b000;
            memValid_q     <= 1'b0;
            memAddr_q      <= 32'h0;
            memWdata_q     <= 32'h0;
            memWstrb_q     <= 4'h0;
            respValid_q    <= 1'b0;
            respLdata_q    <= 32'h0;
            respByteEn_q   <= 4'h0;
            respOp_q       <= 3'b000;
            respErr_q      <= 1'b0;
            respMisalign_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        wr_q     <= req_wr_i;
                        op_q     <= req_op_i;
                        byteEn_q <= byteEn_d;
                        if (trapReq) begin
                            state_q        <= RESP;
                            respValid_q    <= 1'b1;
                            respMisalign_q <= 1'b1;
                            respErr_q      <= 1'b0;
                            respByteEn_q   <= 4'h0;
                            respLdata_q    <= 32'h0;
                            respOp_q       <= req_op_i;
                        end else begin
                            state_q    <= BUSY;
                            waitCnt_q  <= '0;
                            memValid_q <= 1'b1;
                            memAddr_q  <= {req_addr_i[31:2], 2'b00};
                            memWdata_q <= wdata_d;
                            memWstrb_q <= req_wr_i ? byteEn_d : 4'h0;
                        end
                    end
                end
                BUSY: begin
                    if (mem_ready_i || timeoutHit) begin
                        state_q      <= RESP;
                        memValid_q   <= 1'b0;
                        respValid_q  <= 1'b1;
                        respErr_q    <= !mem_ready_i;
                        respByteEn_q <= byteEn_q;
                        respOp_q     <= op_q;
                        respLdata_q  <= (mem_ready_i && !wr_q) ? mem_rdata_i : 32'h0;
                    end else begin
                        waitCnt_q <= waitCnt_q + 1'b1;
                    end
                end
                RESP: begin
                    state_q        <= IDLE;
                    respValid_q    <= 1'b0;
                    respErr_q      <= 1'b0;
                    respMisalign_q <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready_o       = (state_q == IDLE);
    assign mem_valid_o       = memValid_q;
    assign mem_addr_o        = memAddr_q;
    assign mem_wdata_o       = memWdata_q;
    assign mem_wstrb_o       = memWstrb_q;
    assign resp_valid_o      = respValid_q;
    assign resp_ldata_o      = respLdata_q;
    assign resp_byteenable_o = respByteEn_q;
    assign resp_op_o         = respOp_q;
    assign resp_err_o        = respErr_q;
`ifdef MISALIGN_TRAP_EN
    assign resp_misalign_o   = respMisalign_q;
`else
    assign resp_misalign_o   = 1'b0;
    logic unusedMisalign;
    assign unusedMisalign = respMisalign_q;
`endif

endmodule

// File: tb/tb_dmem_access.sv
// tb_dmem_access
//
// Directed bench for dmem_access with the default TIMEOUT of 16. Inputs are
// driven and outputs sampled on the falling clock edge; each observation is
// an immediate assertion against a hand-computed value.

module tb_dmem_access;

    logic        clk;
    logic        rstN;
    logic        reqValid;
    logic        reqReady;
    logic        reqWr;
    logic [2:0]  reqOp;
    logic [31:0] reqAddr;
    logic [31:0] reqSdata;
    logic        memValid;
    logic        memReady;
    logic [31:0] memAddr;
    logic [31:0] memWdata;
    logic [3:0]  memWstrb;
    logic [31:0] memRdata;
    logic        respValid;
    logic [31:0] respLdata;
    logic [3:0]  respByteEn;
    logic [2:0]  respOp;
    logic        respErr;
    logic        respMisalign;

    int vectors;
    int miscompares;
    int mvCount;
    int pulseCount;

    dmem_access #(.TIMEOUT(16)) dut (
        .clk_i             (clk),
        .rst_ni            (rstN),
        .req_valid_i       (reqValid),
        .req_ready_o       (reqReady),
        .req_wr_i          (reqWr),
        .req_op_i          (reqOp),
        .req_addr_i        (reqAddr),
        .req_sdata_i       (reqSdata),
        .mem_valid_o       (memValid),
        .mem_ready_i       (memReady),
        .mem_addr_o        (memAddr),
        .mem_wdata_o       (memWdata),
        .mem_wstrb_o       (memWstrb),
        .mem_rdata_i       (memRdata),
        .resp_valid_o      (respValid),
        .resp_ldata_o      (respLdata),
        .resp_byteenable_o (respByteEn),
        .resp_op_o         (respOp),
        .resp_err_o        (respErr),
        .resp_misalign_o   (respMisalign)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one request onto the execute-side inputs.
    task automatic applyStimulus(input logic valid, input logic wr, input logic [2:0] op,
                                 input logic [31:0] addr, input logic [31:0] sdata);
        reqValid = valid;
        reqWr    = wr;
        reqOp    = op;
        reqAddr  = addr;
        reqSdata = sdata;
    endtask

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Directed sequence of scenarios.
    initial begin
        vectors     = 0;
        miscompares = 0;
        rstN        = 1'b1;
        memReady    = 1'b0;
        memRdata    = 32'h0;
        applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        #2 rstN = 1'b0;

        // Reset state
        @(negedge clk);
        checkOutput("rst_mem_valid", 32'(memValid), 32'h0);
        checkOutput("rst_resp_valid", 32'(respValid), 32'h0);
        checkOutput("rst_resp_ldata", respLdata, 32'h0);
        checkOutput("rst_wstrb", 32'(memWstrb), 32'h0);
        rstN = 1'b1;
        @(negedge clk);
        checkOutput("rst_req_ready", 32'(reqReady), 32'h1);
        checkOutput("rst_resp_err", 32'(respErr), 32'h0);

        // 1: lb 0x1003, bus answers 3 cycles after mem_valid
        $display("[TB] lb with bus wait");
        applyStimulus(1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        checkOutput("lb_mem_valid", 32'(memValid), 32'h1);
        checkOutput("lb_mem_addr", memAddr, 32'h0000_1000);
        checkOutput("lb_wstrb", 32'(memWstrb), 32'h0);
        checkOutput("lb_req_ready", 32'(reqReady), 32'h0);
        @(negedge clk);
        checkOutput("lb_hold_valid", 32'(memValid), 32'h1);
        @(negedge clk);
        checkOutput("lb_hold_addr", memAddr, 32'h0000_1000);
        memReady = 1'b1;
        memRdata = 32'hA1B2_C3D4;
        @(negedge clk);
        memReady = 1'b0;
        memRdata = 32'h0;
        checkOutput("lb_resp_valid", 32'(respValid), 32'h1);
        checkOutput("lb_mem_valid_drop", 32'(memValid), 32'h0);
        checkOutput("lb_ldata", respLdata, 32'hA1B2_C3D4);
        checkOutput("lb_byteenable", 32'(respByteEn), 32'h8);
        checkOutput("lb_op", 32'(respOp), 32'h0);
        checkOutput("lb_err", 32'(respErr), 32'h0);
        @(negedge clk);
        checkOutput("lb_resp_pulse_end", 32'(respValid), 32'h0);
        checkOutput("lb_req_ready_back", 32'(reqReady), 32'h1);

        // 2: sh 0x2002, bus answers immediately
        $display("[TB] sh with immediate ready");
        applyStimulus(1'b1, 1'b1, 3'b001, 32'h0000_2002, 32'h0000_BEEF);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        checkOutput("sh_wdata", memWdata, 32'hBEEF_BEEF);
        checkOutput("sh_wstrb", 32'(memWstrb), 32'hC);
        checkOutput("sh_mem_addr", memAddr, 32'h0000_2000);
        memReady = 1'b1;
        memRdata = 32'h5555_5555;
        @(negedge clk);
        memReady = 1'b0;
        checkOutput("sh_resp_valid", 32'(respValid), 32'h1);
        checkOutput("sh_err", 32'(respErr), 32'h0);
        checkOutput("sh_ldata_store", respLdata, 32'h0);
        checkOutput("sh_byteenable", 32'(respByteEn), 32'hC);
        checkOutput("sh_op", 32'(respOp), 32'h1);
        @(negedge clk);

        // 3: lw 0x10 with no bus response -> timeout after 16 cycles
        $display("[TB] lw timeout");
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'h0);
        mvCount    = 0;
        pulseCount = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
            if (memValid === 1'b1) mvCount++;
            if (respValid === 1'b1) pulseCount++;
        end
        checkOutput("to_mem_valid_cycles", 32'(mvCount), 32'd16);
        checkOutput("to_no_early_resp", 32'(pulseCount), 32'd0);
        @(negedge clk);
        checkOutput("to_resp_valid", 32'(respValid), 32'h1);
        checkOutput("to_resp_err", 32'(respErr), 32'h1);
        checkOutput("to_mem_valid_drop", 32'(memValid), 32'h0);
        checkOutput("to_ldata", respLdata, 32'h0);
        @(negedge clk);
        checkOutput("to_req_ready", 32'(reqReady), 32'h1);
        checkOutput("to_err_clear", 32'(respErr), 32'h0);

        // 3b: mem_ready in the expiry cycle wins over the timeout
        $display("[TB] ready at expiry");
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'h0);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        end
        checkOutput("exp_still_busy", 32'(memValid), 32'h1);
        @(negedge clk);
        checkOutput("exp_last_cycle_valid", 32'(memValid), 32'h1);
        memReady = 1'b1;
        memRdata = 32'hCAFE_F00D;
        @(negedge clk);
        memReady = 1'b0;
        checkOutput("exp_resp_valid", 32'(respValid), 32'h1);
        checkOutput("exp_resp_err", 32'(respErr), 32'h0);
        checkOutput("exp_ldata", respLdata, 32'hCAFE_F00D);
        @(negedge clk);

        // 4: lw 0x0006 (misaligned word)
        $display("[TB] misaligned lw");
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0006, 32'h0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
`ifdef MISALIGN_TRAP_EN
        checkOutput("mis_no_mem_valid", 32'(memValid), 32'h0);
        checkOutput("mis_resp_valid", 32'(respValid), 32'h1);
        checkOutput("mis_resp_misalign", 32'(respMisalign), 32'h1);
        checkOutput("mis_byteenable", 32'(respByteEn), 32'h0);
        checkOutput("mis_ldata", respLdata, 32'h0);
        @(negedge clk);
        checkOutput("mis_pulse_end", 32'(respMisalign), 32'h0);
`else
        checkOutput("mis_mem_valid", 32'(memValid), 32'h1);
        checkOutput("mis_mem_addr", memAddr, 32'h0000_0004);
        checkOutput("mis_wstrb", 32'(memWstrb), 32'h0);
        memReady = 1'b1;
        memRdata = 32'h1122_3344;
        @(negedge clk);
        memReady = 1'b0;
        checkOutput("mis_resp_valid", 32'(respValid), 32'h1);
        checkOutput("mis_resp_misalign", 32'(respMisalign), 32'h0);
        checkOutput("mis_byteenable", 32'(respByteEn), 32'hF);
        checkOutput("mis_ldata", respLdata, 32'h1122_3344);
        @(negedge clk);
`endif

        // 5: back-to-back sb 0x0 / 0x1 with req_valid held
        $display("[TB] back-to-back sb");
        applyStimulus(1'b1, 1'b1, 3'b000, 32'h0000_0000, 32'h0000_0012);
        @(negedge clk);
        checkOutput("b2b_first_wdata", memWdata, 32'h1212_1212);
        checkOutput("b2b_first_wstrb", 32'(memWstrb), 32'h1);
        checkOutput("b2b_busy_not_ready", 32'(reqReady), 32'h0);
        applyStimulus(1'b1, 1'b1, 3'b000, 32'h0000_0001, 32'h0000_0034);
        memReady = 1'b1;
        @(negedge clk);
        memReady = 1'b0;
        checkOutput("b2b_first_resp", 32'(respValid), 32'h1);
        checkOutput("b2b_resp_not_ready", 32'(reqReady), 32'h0);
        checkOutput("b2b_no_mem_valid_resp", 32'(memValid), 32'h0);
        @(negedge clk);
        checkOutput("b2b_no_mem_valid_idle", 32'(memValid), 32'h0);
        checkOutput("b2b_second_ready", 32'(reqReady), 32'h1);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        checkOutput("b2b_second_valid", 32'(memValid), 32'h1);
        checkOutput("b2b_second_wstrb", 32'(memWstrb), 32'h2);
        checkOutput("b2b_second_wdata", memWdata, 32'h3434_3434);
        memReady = 1'b1;
        @(negedge clk);
        memReady = 1'b0;
        checkOutput("b2b_second_resp", 32'(respValid), 32'h1);
        checkOutput("b2b_second_be", 32'(respByteEn), 32'h2);
        @(negedge clk);

        // 6: asynchronous reset while BUSY
        $display("[TB] reset during busy");
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0020, 32'h0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        checkOutput("rb_mem_valid", 32'(memValid), 32'h1);
        #2 rstN = 1'b0;
        #1;
        checkOutput("rb_async_drop", 32'(memValid), 32'h0);
        memReady = 1'b1;
        @(negedge clk);
        rstN       = 1'b1;
        pulseCount = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            memReady = 1'b0;
            if (respValid === 1'b1) pulseCount++;
        end
        checkOutput("rb_no_resp_pulse", 32'(pulseCount), 32'd0);
        checkOutput("rb_req_ready", 32'(reqReady), 32'h1);
        checkOutput("rb_mem_valid_idle", 32'(memValid), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
